// File: rtl/vector_checker.sv
// vector_checker: receiving end of the Boolean/arithmetic test-vector stream.
// Accepts 8-bit vectors {A,B,cin,sum,carry,and,or,xor} and drives A/B/cin to a
// 1-bit ALU slice. It compares the slice result against the expected fields a fixed
// latency later. It reports pass/fail, the error count and the first failing vector.
//
// Ports:
//   clk, reset       rising-edge clock, async active-low reset
//   start            1-cycle pulse, begins a run from IDLE or DONE
//   vec_valid/vec_in vector stream, accepted when vec_valid & vec_ready
//   vec_ready        high while in RUN
//   dut_a/b/cin      registered stimulus to the ALU slice
//   dut_res          ALU slice result {sum,carry,and,or,xor}
//   busy/done/pass   run status
//   chk_count        vectors compared this run
//   err_count        mismatching vectors this run (saturating)
//   fail_vector      first mismatching vector as received
//   fail_got         dut_res observed for fail_vector
module vector_checker #(
  parameter int unsigned DUT_LATENCY = 1,
  parameter int unsigned NUM_VECTORS = 8,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             vec_valid,
  input  logic [7:0]       vec_in,
  output logic             vec_ready,
  output logic             dut_a,
  output logic             dut_b,
  output logic             dut_cin,
  input  logic [4:0]       dut_res,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] chk_count,
  output logic [CNT_W-1:0] err_count,
  output logic [7:0]       fail_vector,
  output logic [4:0]       fail_got
);

  // Expected-value line: stage DUT_LATENCY lines up with dut_res.
  localparam int unsigned     DEPTH     = DUT_LATENCY + 1;
  localparam int unsigned     TAIL      = DUT_LATENCY;
  localparam logic [DEPTH-1:0] TAIL_MASK = DEPTH'(1) << TAIL;
  localparam logic [CNT_W-1:0] LAST_ACC  = CNT_W'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_acc_cnt, w_acc_nxt;
  logic [CNT_W-1:0] w_chk_nxt, w_err_nxt;
  logic [7:0]       w_fv_nxt;
  logic [4:0]       w_fg_nxt;
  logic [7:0]       r_dly [DEPTH];
  logic [DEPTH-1:0] r_dly_v;
  logic             w_accept, w_cmp, w_mis, w_others;

  assign w_accept = vec_valid && (r_state == S_RUN);
  assign w_cmp    = r_dly_v[TAIL];
  assign w_mis    = w_cmp && (dut_res != r_dly[TAIL][4:0]);
  // Slots still in flight behind the one being compared this cycle.
  assign w_others = |(r_dly_v & ~TAIL_MASK);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state, counters and first-failure capture
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc_cnt;
    w_chk_nxt   = chk_count;
    w_err_nxt   = err_count;
    w_fv_nxt    = fail_vector;
    w_fg_nxt    = fail_got;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_acc_nxt   = '0;
          w_chk_nxt   = '0;
          w_err_nxt   = '0;
          w_fv_nxt    = '0;
          w_fg_nxt    = '0;
        end
      end
      S_RUN: begin
        if (w_accept) begin
          w_acc_nxt = r_acc_cnt + CNT_W'(1);
          if (r_acc_cnt == LAST_ACC) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_cmp && !w_others) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // The line is empty in IDLE/DONE, so comparing never collides with the clear above.
    if (w_cmp) begin
      w_chk_nxt = chk_count + CNT_W'(1);
      if (w_mis) begin
        if (err_count != '1) w_err_nxt = err_count + CNT_W'(1);
        if (err_count == '0) begin
          w_fv_nxt = r_dly[TAIL];
          w_fg_nxt = dut_res;
        end
      end
    end
  end

  // Registered outputs, stimulus and expected-value delay line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc_cnt   <= '0;
      chk_count   <= '0;
      err_count   <= '0;
      fail_vector <= '0;
      fail_got    <= '0;
      vec_ready   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      dut_a       <= 1'b0;
      dut_b       <= 1'b0;
      dut_cin     <= 1'b0;
      r_dly_v     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_dly[i] <= '0;
    end else begin
      r_acc_cnt   <= w_acc_nxt;
      chk_count   <= w_chk_nxt;
      err_count   <= w_err_nxt;
      fail_vector <= w_fv_nxt;
      fail_got    <= w_fg_nxt;
      vec_ready   <= (w_state_nxt == S_RUN);
      busy        <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
      done        <= (w_state_nxt == S_DONE);
      pass        <= (w_state_nxt == S_DONE) && (w_err_nxt == '0);
      if (w_accept) begin
        dut_a   <= vec_in[7];
        dut_b   <= vec_in[6];
        dut_cin <= vec_in[5];
        r_dly[0] <= vec_in;
      end
      r_dly_v[0] <= w_accept;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_dly_v[i] <= r_dly_v[i-1];
        r_dly[i]   <= r_dly[i-1];
      end
    end
  end

endmodule

// File: tb/tb_vector_checker.sv
// tb_vector_checker: directed bench for vector_checker. Four builds share the vector
// stream and reset: main (latency 1, 8 vectors), latency 0, latency 3, and a
// saturation build (CNT_W=2, 3 vectors) driven by an always-wrong ALU slice.
module tb_vector_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       vec_valid;
  logic [7:0] vec_in;
  logic [3:0] start_v;
  logic       fault_xor;

  logic [3:0] rdy_v, a_v, b_v, cin_v, busy_v, done_v, pass_v;
  logic [4:0] res_m, res_0, res_3, res_s;
  logic [7:0] chk_m, err_m, chk_0, err_0, chk_3, err_3;
  logic [1:0] chk_s, err_s;
  logic [7:0] fv_m, fv_0, fv_3, fv_s;
  logic [4:0] fg_m, fg_0, fg_3, fg_s;

  int n_tests = 0;
  int n_fail  = 0;
  int n;

  always #5 clk = ~clk;

  // Reference 1-bit ALU slice: {sum, carry, and, or, xor}
  function automatic logic [4:0] alu(input logic a, input logic b, input logic c);
    return {a ^ b ^ c, (a & b) | (a & c) | (b & c), a & b, a | b, a ^ b};
  endfunction

  function automatic logic [7:0] make_vec(input logic [2:0] abc);
    return {abc, alu(abc[2], abc[1], abc[0])};
  endfunction

  // ALU slice models for each build
  logic [4:0] r_m, p1, p2, p3, r_s;
  always @(posedge clk) begin
    r_m <= alu(a_v[0], b_v[0], cin_v[0]);
    p1  <= alu(a_v[2], b_v[2], cin_v[2]);
    p2  <= p1;
    p3  <= p2;
    r_s <= ~alu(a_v[3], b_v[3], cin_v[3]);
  end
  assign res_m = fault_xor ? {r_m[4:1], 1'b0} : r_m;
  assign res_0 = alu(a_v[1], b_v[1], cin_v[1]);
  assign res_3 = p3;
  assign res_s = r_s;

  vector_checker #(.DUT_LATENCY(1), .NUM_VECTORS(8), .CNT_W(8)) u_main (
    .clk(clk), .reset(reset), .start(start_v[0]), .vec_valid(vec_valid), .vec_in(vec_in),
    .vec_ready(rdy_v[0]), .dut_a(a_v[0]), .dut_b(b_v[0]), .dut_cin(cin_v[0]), .dut_res(res_m),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .chk_count(chk_m), .err_count(err_m),
    .fail_vector(fv_m), .fail_got(fg_m));

  vector_checker #(.DUT_LATENCY(0), .NUM_VECTORS(8), .CNT_W(8)) u_l0 (
    .clk(clk), .reset(reset), .start(start_v[1]), .vec_valid(vec_valid), .vec_in(vec_in),
    .vec_ready(rdy_v[1]), .dut_a(a_v[1]), .dut_b(b_v[1]), .dut_cin(cin_v[1]), .dut_res(res_0),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .chk_count(chk_0), .err_count(err_0),
    .fail_vector(fv_0), .fail_got(fg_0));

  vector_checker #(.DUT_LATENCY(3), .NUM_VECTORS(8), .CNT_W(8)) u_l3 (
    .clk(clk), .reset(reset), .start(start_v[2]), .vec_valid(vec_valid), .vec_in(vec_in),
    .vec_ready(rdy_v[2]), .dut_a(a_v[2]), .dut_b(b_v[2]), .dut_cin(cin_v[2]), .dut_res(res_3),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .chk_count(chk_3), .err_count(err_3),
    .fail_vector(fv_3), .fail_got(fg_3));

  vector_checker #(.DUT_LATENCY(1), .NUM_VECTORS(3), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .start(start_v[3]), .vec_valid(vec_valid), .vec_in(vec_in),
    .vec_ready(rdy_v[3]), .dut_a(a_v[3]), .dut_b(b_v[3]), .dut_cin(cin_v[3]), .dut_res(res_s),
    .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]), .chk_count(chk_s), .err_count(err_s),
    .fail_vector(fv_s), .fail_got(fg_s));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic start_run(input int idx);
    start_v[idx] = 1'b1;
    @(negedge clk);
    start_v = '0;
  endtask

  task automatic send(input logic [7:0] v);
    vec_valid = 1'b1;
    vec_in    = v;
    @(negedge clk);
    vec_valid = 1'b0;
  endtask

  // Cycles from the last accept's negedge until done, bounded.
  task automatic wait_done(input int idx, output int cnt);
    cnt = 0;
    while (!done_v[idx] && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  logic [7:0] t2_vecs [8] = '{8'h00, 8'h30, 8'h53, 8'hCE, 8'hFE, 8'h00, 8'h30, 8'hCE};

  initial begin
    reset = 1'b0; vec_valid = 1'b0; vec_in = '0; start_v = '0; fault_xor = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy_v), 32'h0);
    check("rst_done_pass_rdy", 32'({done_v, pass_v, rdy_v}), 32'h0);
    check("rst_counts", 32'({chk_m, err_m}), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // 1: ideal slice, eight back-to-back vectors covering every A/B/cin
    start_run(0);
    check("t1_ready", 32'({rdy_v[0], busy_v[0]}), 32'h3);
    for (int i = 0; i < 8; i++) begin
      send(make_vec(3'(i)));
      check("t1_stim", 32'({a_v[0], b_v[0], cin_v[0]}), 32'(i));
    end
    wait_done(0, n);
    check("t1_drain", 32'(n), 32'd2);
    check("t1_pass", 32'(pass_v[0]), 32'h1);
    check("t1_chk", 32'(chk_m), 32'd8);
    check("t1_err", 32'(err_m), 32'd0);
    check("t1_idle_outs", 32'({busy_v[0], rdy_v[0]}), 32'h0);

    // 2: slice forces xor=0; only slot 2 (8'h53) expects xor=1
    fault_xor = 1'b1;
    start_run(0);
    for (int i = 0; i < 8; i++) send(t2_vecs[i]);
    wait_done(0, n);
    check("t2_drain", 32'(n), 32'd2);
    check("t2_err", 32'(err_m), 32'd1);
    check("t2_fail_vector", 32'(fv_m), 32'h53);
    check("t2_fail_got", 32'(fg_m), 32'h12);
    check("t2_pass", 32'(pass_v[0]), 32'h0);
    check("t2_chk", 32'(chk_m), 32'd8);
    fault_xor = 1'b0;

    // 3: bubbles between valid vectors
    start_run(0);
    for (int i = 0; i < 8; i++) begin
      send(make_vec(3'(7 - i)));
      if (i < 7) begin
        repeat (2) @(negedge clk);
        check("t3_busy", 32'(busy_v[0]), 32'h1);
      end
    end
    wait_done(0, n);
    check("t3_chk", 32'(chk_m), 32'd8);
    check("t3_err", 32'(err_m), 32'd0);
    check("t3_fail_vector", 32'(fv_m), 32'h0);
    check("t3_pass", 32'(pass_v[0]), 32'h1);

    // 4: latency 0 and latency 3 builds
    start_run(1);
    for (int i = 0; i < 8; i++) send(make_vec(3'(i)));
    wait_done(1, n);
    check("t4_l0_drain", 32'(n), 32'd1);
    check("t4_l0_result", 32'({pass_v[1], chk_0, err_0}), {23'd0, 1'b1, 8'd8, 8'd0});
    start_run(2);
    for (int i = 0; i < 8; i++) send(make_vec(3'(i)));
    wait_done(2, n);
    check("t4_l3_drain", 32'(n), 32'd4);
    check("t4_l3_result", 32'({pass_v[2], chk_3, err_3}), {23'd0, 1'b1, 8'd8, 8'd0});

    // 5: reset mid-run after four accepts, then a fresh run
    start_run(0);
    for (int i = 0; i < 4; i++) send(make_vec(3'(i)));
    check("t5_pre_chk", 32'(chk_m), 32'd2);
    check("t5_pre_stim", 32'({a_v[0], b_v[0], cin_v[0]}), 32'd3);
    #1 reset = 1'b0;
    #1;
    check("t5_rst_status", 32'({busy_v, done_v, pass_v, rdy_v}), 32'h0);
    check("t5_rst_stim", 32'({a_v, b_v, cin_v}), 32'h0);
    check("t5_rst_counts", 32'({chk_m, err_m}), 32'h0);
    check("t5_rst_fail", 32'({fv_m, fg_m}), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t5_idle", 32'({busy_v[0], done_v[0]}), 32'h0);
    start_run(0);
    for (int i = 0; i < 8; i++) send(make_vec(3'(i)));
    wait_done(0, n);
    check("t5_drain", 32'(n), 32'd2);
    check("t5_result", 32'({pass_v[0], chk_m, err_m}), {23'd0, 1'b1, 8'd8, 8'd0});

    // 6: always-wrong slice, 2-bit counters, start while busy ignored
    start_run(3);
    send(8'h00);
    send(8'h53);
    start_v[3] = 1'b1;
    @(negedge clk);
    start_v = '0;
    check("t6_busy", 32'(busy_v[3]), 32'h1);
    send(8'hFE);
    wait_done(3, n);
    check("t6_drain", 32'(n), 32'd2);
    check("t6_err_sat", 32'(err_s), 32'd3);
    check("t6_chk", 32'(chk_s), 32'd3);
    check("t6_pass", 32'(pass_v[3]), 32'h0);
    check("t6_fail_vector", 32'(fv_s), 32'h00);
    check("t6_fail_got", 32'(fg_s), 32'h1F);
    repeat (3) @(negedge clk);
    check("t6_hold", 32'({done_v[3], err_s, chk_s}), 32'h1F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
